// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported RAM between instruction fetch (read-only) and the data port.
// Each transaction runs IDLE -> ISSUE -> WAIT -> RESP; DM has priority, bounded by a streak limit.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int RAM_LATENCY   = 1,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              dm_req_valid,
  input  logic              dm_req_write,
  input  logic [ADDR_W-1:0] dm_req_addr,
  input  logic [DATA_W-1:0] dm_req_wdata,
  output logic              dm_req_ready,
  output logic              dm_rsp_valid,
  output logic [DATA_W-1:0] dm_rsp_data,
  output logic              ram_read_enable,
  output logic              ram_write_enable,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy
);

  localparam int CNT_W    = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);
  localparam logic [CNT_W-1:0]    WAIT_LOAD  = CNT_W'(RAM_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              state_reg;
  logic                owner_dm_reg;
  logic                write_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [CNT_W-1:0]    wait_cnt_reg;
  logic [STREAK_W-1:0] streak_reg;
  logic [DATA_W-1:0]   if_rsp_data_reg;
  logic [DATA_W-1:0]   dm_rsp_data_reg;
  logic                grant_dm;
  logic                grant_if;

  // IF only overrides DM once DM has won MAX_DM_STREAK times in a row while IF waited.
  always_comb begin
    grant_dm = (state_reg == S_IDLE) && dm_req_valid &&
               !(if_req_valid && (streak_reg == STREAK_MAX));
    grant_if = (state_reg == S_IDLE) && if_req_valid && !grant_dm;
  end

  assign dm_req_ready     = grant_dm;
  assign if_req_ready     = grant_if;
  assign ram_read_enable  = (state_reg == S_ISSUE) && !write_reg;
  assign ram_write_enable = (state_reg == S_ISSUE) && write_reg;
  assign ram_address      = (state_reg == S_ISSUE) ? addr_reg  : '0;
  assign ram_data_in      = (state_reg == S_ISSUE) ? wdata_reg : '0;
  assign if_rsp_valid     = (state_reg == S_RESP) && !owner_dm_reg;
  assign dm_rsp_valid     = (state_reg == S_RESP) && owner_dm_reg;
  assign if_rsp_data      = if_rsp_data_reg;
  assign dm_rsp_data      = dm_rsp_data_reg;
  assign busy             = (state_reg != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= S_IDLE;
      owner_dm_reg    <= 1'b0;
      write_reg       <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      wait_cnt_reg    <= '0;
      streak_reg      <= '0;
      if_rsp_data_reg <= '0;
      dm_rsp_data_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (grant_dm || grant_if) begin
            owner_dm_reg <= grant_dm;
            write_reg    <= grant_dm && dm_req_write;
            addr_reg     <= grant_dm ? dm_req_addr  : if_req_addr;
            wdata_reg    <= grant_dm ? dm_req_wdata : '0;
            state_reg    <= S_ISSUE;
          end
          if (grant_if) begin
            streak_reg <= '0;
          end else if (grant_dm) begin
            if (!if_req_valid)
              streak_reg <= '0;
            else if (streak_reg != STREAK_MAX)
              streak_reg <= streak_reg + 1'b1;
          end
        end
        S_ISSUE: begin
          wait_cnt_reg <= WAIT_LOAD;
          state_reg    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_reg == '0) begin
            // Capture straight into the owner's data register so RESP has no path from the RAM.
            if (owner_dm_reg)
              dm_rsp_data_reg <= write_reg ? '0 : ram_data_out;
            else
              if_rsp_data_reg <= ram_data_out;
            state_reg <= S_RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
          end
        end
        S_RESP: state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
